// File: rtl/clct_two_pass_sequencer_pkg.sv
// Shared constants, types and helpers for the two-pass CLCT sequencer.
// The pattern word carries nhits in its top three bits and the bend lsb in bit 0.
package clct_two_pass_sequencer_pkg;

  localparam int PAT_W      = 11;
  localparam int KEY_W      = 5;
  localparam int KEYX_W     = 8;
  localparam int CC_W       = 12;
  localparam int NGRP       = 5;
  localparam int GRP_W      = 3;
  localparam int BUSY_EDGE  = 2;
  localparam int HS_PER_GRP = 1 << KEY_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_P1,
    ST_P2
  } state_t;

  typedef struct packed {
    logic              vld;
    logic [PAT_W-1:0]  pat;
    logic [KEYX_W-1:0] key;
    logic [CC_W-1:0]   carry;
  } clct_t;

  function automatic logic [2:0] nhits(input logic [PAT_W-1:0] pat);
    return pat[PAT_W-1 -: 3];
  endfunction

  // Winner group plus any neighbour its key sits close to; no wrap past grp0 or grp4.
  function automatic logic [NGRP-1:0] neighbour_mask(input logic [GRP_W-1:0] grp,
                                                     input logic [KEY_W-1:0] key);
    logic [NGRP-1:0] m;
    m = '0;
    for (int g = 0; g < NGRP; g++) begin
      if (int'(grp) == g)                                          m[g] = 1'b1;
      if (int'(key) < BUSY_EDGE && int'(grp) == g + 1)             m[g] = 1'b1;
      if (int'(key) >= HS_PER_GRP - BUSY_EDGE && int'(grp) + 1 == g) m[g] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/clct_two_pass_sequencer_if.sv
// Event bus between the per-group pattern finders and the CLCT output logic.
// The master drives the event, the slave (the sequencer) returns the two CLCTs.
interface clct_two_pass_sequencer_if;
  import clct_two_pass_sequencer_pkg::*;

  logic                            start;
  logic [NGRP-1:0][PAT_W-1:0]      pat_in;
  logic [NGRP-1:0][KEY_W-1:0]      key_in;
  logic [NGRP-1:0][CC_W-1:0]       carry_in;
  logic [NGRP-1:0]                 ext_busy;
  logic [2:0]                      hit_thresh;

  logic                            clct0_vld;
  logic [PAT_W-1:0]                clct0_pat;
  logic [KEYX_W-1:0]               clct0_key;
  logic [CC_W-1:0]                 clct0_carry;
  logic                            clct1_vld;
  logic [PAT_W-1:0]                clct1_pat;
  logic [KEYX_W-1:0]               clct1_key;
  logic [CC_W-1:0]                 clct1_carry;
  logic                            done;
  logic                            seq_busy;
  logic                            start_drop;

  modport master (
    output start, pat_in, key_in, carry_in, ext_busy, hit_thresh,
    input  clct0_vld, clct0_pat, clct0_key, clct0_carry,
           clct1_vld, clct1_pat, clct1_key, clct1_carry,
           done, seq_busy, start_drop
  );

  modport slave (
    input  start, pat_in, key_in, carry_in, ext_busy, hit_thresh,
    output clct0_vld, clct0_pat, clct0_key, clct0_carry,
           clct1_vld, clct1_pat, clct1_key, clct1_carry,
           done, seq_busy, start_drop
  );
endinterface

// File: rtl/clct_two_pass_sequencer_sorter.sv
// Combinational best-of-5 sorter with a per-group busy mask.
// Bend lsb is excluded from the compare; ties resolve to the lower group index.
module clct_two_pass_sequencer_sorter
  import clct_two_pass_sequencer_pkg::*;
(
  input  logic [NGRP-1:0][PAT_W-1:0] pat,
  input  logic [NGRP-1:0][KEY_W-1:0] key,
  input  logic [NGRP-1:0][CC_W-1:0]  carry,
  input  logic [NGRP-1:0]            busy,
  output clct_t                      best,
  output logic [GRP_W-1:0]           best_grp
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    best     = '0;
    best_grp = '0;
    for (int g = 0; g < NGRP; g++) begin
      if (!busy[g] && (!best.vld || pat[g][PAT_W-1:1] > best.pat[PAT_W-1:1])) begin
        best.vld   = 1'b1;
        best.pat   = pat[g];
        best.key   = {GRP_W'(g), key[g]};
        best.carry = carry[g];
        best_grp   = GRP_W'(g);
      end
    end
  end

endmodule

// File: rtl/clct_two_pass_sequencer.sv
// Runs one shared best-of-5 sorter twice per event: pass 1 finds CLCT0, pass 2
// masks CLCT0's group and close neighbours and finds CLCT1; both publish together.
module clct_two_pass_sequencer
  import clct_two_pass_sequencer_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  clct_two_pass_sequencer_if.slave bus
);

  state_t                     state;
  logic [NGRP-1:0][PAT_W-1:0] cap_pat;
  logic [NGRP-1:0][KEY_W-1:0] cap_key;
  logic [NGRP-1:0][CC_W-1:0]  cap_carry;
  logic [NGRP-1:0]            cap_ext_busy;
  logic [2:0]                 cap_thresh;

  clct_t                      c0_int;
  logic [GRP_W-1:0]           c0_grp;
  clct_t                      out0;
  clct_t                      out1;
  logic                       done;
  logic                       seq_busy;
  logic                       start_drop;

  logic [NGRP-1:0]            busy1;
  logic [NGRP-1:0]            busy2;
  logic [NGRP-1:0]            sort_busy;
  clct_t                      sort_best;
  logic [GRP_W-1:0]           sort_grp;

  always_comb begin
    busy1 = '0;
    for (int g = 0; g < NGRP; g++) begin
      busy1[g] = cap_ext_busy[g] | (nhits(cap_pat[g]) < cap_thresh);
    end
    // An empty pass 1 leaves nothing for pass 2 either.
    busy2     = c0_int.vld ? (busy1 | neighbour_mask(c0_grp, c0_int.key[KEY_W-1:0])) : '1;
    sort_busy = (state == ST_P2) ? busy2 : busy1;
  end

  clct_two_pass_sequencer_sorter u_sorter (
    .pat      (cap_pat),
    .key      (cap_key),
    .carry    (cap_carry),
    .busy     (sort_busy),
    .best     (sort_best),
    .best_grp (sort_grp)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      cap_pat      <= '0;
      cap_key      <= '0;
      cap_carry    <= '0;
      cap_ext_busy <= '0;
      cap_thresh   <= '0;
      c0_int       <= '0;
      c0_grp       <= '0;
      out0         <= '0;
      out1         <= '0;
      done         <= 1'b0;
      seq_busy     <= 1'b0;
      start_drop   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.start && state != ST_IDLE) start_drop <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            cap_pat      <= bus.pat_in;
            cap_key      <= bus.key_in;
            cap_carry    <= bus.carry_in;
            cap_ext_busy <= bus.ext_busy;
            cap_thresh   <= bus.hit_thresh;
            seq_busy     <= 1'b1;
            state        <= ST_P1;
          end
        end
        ST_P1: begin
          c0_int <= sort_best;
          c0_grp <= sort_grp;
          state  <= ST_P2;
        end
        ST_P2: begin
          out0     <= c0_int;
          out1     <= sort_best;
          done     <= 1'b1;
          seq_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          seq_busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.clct0_vld   = out0.vld;
  assign bus.clct0_pat   = out0.pat;
  assign bus.clct0_key   = out0.key;
  assign bus.clct0_carry = out0.carry;
  assign bus.clct1_vld   = out1.vld;
  assign bus.clct1_pat   = out1.pat;
  assign bus.clct1_key   = out1.key;
  assign bus.clct1_carry = out1.carry;
  assign bus.done        = done;
  assign bus.seq_busy    = seq_busy;
  assign bus.start_drop  = start_drop;

endmodule

// File: tb/tb_clct_two_pass_sequencer.sv
// Directed bench for the two-pass CLCT sequencer with hand-computed expectations.
module tb_clct_two_pass_sequencer;
  import clct_two_pass_sequencer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  clct_two_pass_sequencer_if bus ();

  clct_two_pass_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_grp(input int g, input logic [PAT_W-1:0] p,
                         input logic [KEY_W-1:0] k, input logic [CC_W-1:0] c);
    bus.pat_in[g]   = p;
    bus.key_in[g]   = k;
    bus.carry_in[g] = c;
  endtask

  task automatic check_out(input string tag,
                           input logic v0, input logic [PAT_W-1:0] p0, input logic [KEYX_W-1:0] k0,
                           input logic [CC_W-1:0] c0,
                           input logic v1, input logic [PAT_W-1:0] p1, input logic [KEYX_W-1:0] k1,
                           input logic [CC_W-1:0] c1);
    check({tag, " clct0_vld"},   32'(bus.clct0_vld),   32'(v0));
    check({tag, " clct0_pat"},   32'(bus.clct0_pat),   32'(p0));
    check({tag, " clct0_key"},   32'(bus.clct0_key),   32'(k0));
    check({tag, " clct0_carry"}, 32'(bus.clct0_carry), 32'(c0));
    check({tag, " clct1_vld"},   32'(bus.clct1_vld),   32'(v1));
    check({tag, " clct1_pat"},   32'(bus.clct1_pat),   32'(p1));
    check({tag, " clct1_key"},   32'(bus.clct1_key),   32'(k1));
    check({tag, " clct1_carry"}, 32'(bus.clct1_carry), 32'(c1));
  endtask

  // Pulses start in cycle c and checks done is low at c+1, c+2 and high at c+3.
  task automatic run_event(input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, " done c+1"}, 32'(bus.done), 32'd0);
    check({tag, " busy c+1"}, 32'(bus.seq_busy), 32'd1);
    tick();
    check({tag, " done c+2"}, 32'(bus.done), 32'd0);
    tick();
    check({tag, " done c+3"}, 32'(bus.done), 32'd1);
    check({tag, " busy c+3"}, 32'(bus.seq_busy), 32'd0);
  endtask

  task automatic load_single_winner();
    bus.ext_busy   = 5'b00000;
    bus.hit_thresh = 3'd3;
    set_grp(0, 11'h300, 5'd3,  12'h100);
    set_grp(1, 11'h301, 5'd4,  12'h101);
    set_grp(2, 11'h620, 5'd10, 12'h102);
    set_grp(3, 11'h300, 5'd5,  12'h103);
    set_grp(4, 11'h300, 5'd6,  12'h104);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.pat_in     = '0;
    bus.key_in     = '0;
    bus.carry_in   = '0;
    bus.ext_busy   = '0;
    bus.hit_thresh = '0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_out("reset", 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset seq_busy", 32'(bus.seq_busy), 32'd0);
    check("reset start_drop", 32'(bus.start_drop), 32'd0);

    // 1: single winner in grp2; grp1 differs only in bend lsb so the tie goes to grp0.
    load_single_winner();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.pat_in = '0;   // changes after capture must not matter
    tick();
    check("t1 done c+2", 32'(bus.done), 32'd0);
    tick();
    check("t1 done c+3", 32'(bus.done), 32'd1);
    check_out("t1", 1'b1, 11'h620, 8'h4A, 12'h102, 1'b1, 11'h300, 8'h03, 12'h100);
    tick();
    check("t1 done c+4", 32'(bus.done), 32'd0);
    check("t1 held key0", 32'(bus.clct0_key), 32'h4A);

    // 2: grp1 key 31 masks grp2, so CLCT1 comes from grp3.
    bus.ext_busy   = 5'b00000;
    bus.hit_thresh = 3'd3;
    set_grp(0, 11'h200, 5'd0,  12'h110);
    set_grp(1, 11'h600, 5'd31, 12'h111);
    set_grp(2, 11'h500, 5'd0,  12'h112);
    set_grp(3, 11'h400, 5'd7,  12'h113);
    set_grp(4, 11'h200, 5'd1,  12'h114);
    run_event("t2");
    check_out("t2", 1'b1, 11'h600, 8'h3F, 12'h111, 1'b1, 11'h400, 8'h67, 12'h113);

    // 3a: nothing reaches threshold.
    bus.ext_busy   = 5'b00000;
    bus.hit_thresh = 3'd3;
    for (int g = 0; g < NGRP; g++) set_grp(g, 11'h2F0, 5'(g + 1), 12'hABC);
    run_event("t3a");
    check_out("t3a", 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);

    // 3b: only grp0 is not externally masked.
    bus.ext_busy   = 5'b11110;
    set_grp(0, 11'h400, 5'd12, 12'h0AB);
    for (int g = 1; g < NGRP; g++) set_grp(g, 11'h700, 5'd9, 12'hFFF);
    run_event("t3b");
    check_out("t3b", 1'b1, 11'h400, 8'h0C, 12'h0AB, 1'b0, '0, '0, '0);

    // 6: grp4 key 0 masks grp3 without reaching past grp4.
    bus.ext_busy   = 5'b00000;
    bus.hit_thresh = 3'd3;
    set_grp(0, 11'h300, 5'd1, 12'h120);
    set_grp(1, 11'h400, 5'd2, 12'h121);
    set_grp(2, 11'h500, 5'd3, 12'h122);
    set_grp(3, 11'h600, 5'd9, 12'h123);
    set_grp(4, 11'h700, 5'd0, 12'h124);
    run_event("t6");
    check_out("t6", 1'b1, 11'h700, 8'h80, 12'h124, 1'b1, 11'h500, 8'h43, 12'h122);
    check("t6 no drop yet", 32'(bus.start_drop), 32'd0);

    // 4: start held six cycles -> done at c+3 and c+6 only.
    load_single_winner();
    bus.start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 6) bus.start = 1'b0;
      check($sformatf("t4 done c+%0d", k), 32'(bus.done), 32'((k == 3 || k == 6) ? 1 : 0));
    end
    check("t4 start_drop", 32'(bus.start_drop), 32'd1);
    check("t4 key0", 32'(bus.clct0_key), 32'h4A);
    check("t4 key1", 32'(bus.clct1_key), 32'h03);
    tick();
    check("t4 idle after", 32'(bus.seq_busy), 32'd0);

    // 5: reset during P2 aborts the event and clears everything.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5 no done", 32'(bus.done), 32'd0);
    check("t5 seq_busy", 32'(bus.seq_busy), 32'd0);
    check("t5 start_drop", 32'(bus.start_drop), 32'd0);
    check_out("t5 cleared", 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    tick();
    check("t5 still no done", 32'(bus.done), 32'd0);
    run_event("t5 restart");
    check_out("t5 restart", 1'b1, 11'h620, 8'h4A, 12'h102, 1'b1, 11'h300, 8'h03, 12'h100);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
